// File: rtl/prio_encoder_en_if.sv
// Request/grant bus for prio_encoder_en: enabled request pulses in, indexed valid/ready output.
interface prio_encoder_en_if #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 2
);
    logic         E;
    logic [N-1:0] REQ;
    logic         OUT_READY;
    logic         OUT_VALID;
    logic [W-1:0] OUT_IDX;
    logic [N-1:0] PENDING;
    logic         ERR_DUP;

    // Requester/consumer side
    modport master (
        output E, REQ, OUT_READY,
        input  OUT_VALID, OUT_IDX, PENDING, ERR_DUP
    );

    // Encoder side
    modport slave (
        input  E, REQ, OUT_READY,
        output OUT_VALID, OUT_IDX, PENDING, ERR_DUP
    );
endinterface

// File: rtl/prio_encoder_en.sv
// Sequential N-to-log2(N) priority encoder: sticky pending register served one index at a time.
// Optional macro PRIO_ENCODER_ROUND_ROBIN_EN switches fixed lowest-index priority to round-robin.
module prio_encoder_en #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 2
) (
    input  logic               clk,
    input  logic               rst,
    prio_encoder_en_if.slave   bus
);

    typedef enum logic [0:0] {IDLE = 1'b0, HOLD = 1'b1} state_e;

    state_e       state_q, state_d;
    logic [N-1:0] pending_q, pending_d;
    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_idx_q, out_idx_d;
    logic         err_dup_q, err_dup_d;

    logic         fire;
    logic [N-1:0] clr;
    logic [N-1:0] set;
    logic [N-1:0] rem;

`ifdef PRIO_ENCODER_ROUND_ROBIN_EN
    logic [W-1:0] rr_ptr_q, rr_ptr_d;

    // First set bit searching upward from ptr+1, wrapping modulo N
    function automatic logic [W-1:0] select(input logic [N-1:0] v, input logic [W-1:0] ptr);
        logic [W-1:0] idx;
        logic [W-1:0] cand;
        logic         found;
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= int'(N); k++) begin
            cand = ptr + W'(k);
            if (!found && v[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
        return idx;
    endfunction
`else
    // Lowest set index wins
    function automatic logic [W-1:0] select(input logic [N-1:0] v);
        logic [W-1:0] idx;
        idx = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (v[i]) idx = W'(i);
        end
        return idx;
    endfunction
`endif

    assign fire = out_valid_q & bus.OUT_READY;
    assign clr  = fire ? (N'(1) << out_idx_q) : '0;
    assign set  = bus.E ? bus.REQ : '0;
    assign rem  = pending_q & ~clr;

    // Pending bookkeeping, duplicate detection and output FSM
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        pending_d   = rem | set;
        err_dup_d   = |(set & pending_q & ~clr);
`ifdef PRIO_ENCODER_ROUND_ROBIN_EN
        rr_ptr_d    = fire ? out_idx_q : rr_ptr_q;
`endif
        unique case (state_q)
            IDLE: begin
                out_valid_d = 1'b0;
                if (pending_q != '0) begin
                    state_d     = HOLD;
                    out_valid_d = 1'b1;
`ifdef PRIO_ENCODER_ROUND_ROBIN_EN
                    out_idx_d   = select(pending_q, rr_ptr_q);
`else
                    out_idx_d   = select(pending_q);
`endif
                end
            end
            HOLD: begin
                out_valid_d = 1'b1;
                if (fire) begin
                    // Same-cycle requests are not in rem; they get served on a later pass
                    if (rem != '0) begin
`ifdef PRIO_ENCODER_ROUND_ROBIN_EN
                        out_idx_d = select(rem, out_idx_q);
`else
                        out_idx_d = select(rem);
`endif
                    end else begin
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            err_dup_q   <= 1'b0;
`ifdef PRIO_ENCODER_ROUND_ROBIN_EN
            rr_ptr_q    <= W'(N - 1);
`endif
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            err_dup_q   <= err_dup_d;
`ifdef PRIO_ENCODER_ROUND_ROBIN_EN
            rr_ptr_q    <= rr_ptr_d;
`endif
        end
    end

    assign bus.OUT_VALID = out_valid_q;
    assign bus.OUT_IDX   = out_idx_q;
    assign bus.PENDING   = pending_q;
    assign bus.ERR_DUP   = err_dup_q;

endmodule

// File: tb/tb_prio_encoder_en.sv
// Directed self-checking bench for prio_encoder_en (N=4); outputs sampled 1ns after each rising edge.
module tb_prio_encoder_en;
    localparam int unsigned N = 4;
    localparam int unsigned W = 2;

    logic clk = 1'b0;
    logic rst;
    int unsigned vecs = 0;
    int unsigned miss = 0;

    always #5 clk = ~clk;

    prio_encoder_en_if #(.N(N), .W(W)) bus ();
    prio_encoder_en #(.N(N), .W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; bus.E = 1'b0; bus.REQ = '0; bus.OUT_READY = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.E = 1'b1; bus.REQ = 4'b1111; bus.OUT_READY = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            vecs++;
            if (bus.OUT_VALID !== 1'b0 || bus.PENDING !== 4'b0000 || bus.ERR_DUP !== 1'b0) begin
                miss++;
                $display("FAIL reset_hold%0d: valid=%b pending=%b err=%b, want 0/0000/0", i, bus.OUT_VALID, bus.PENDING, bus.ERR_DUP);
            end
        end
        rst = 1'b0; bus.REQ = '0;
        tick();
        vecs++;
        if (bus.OUT_VALID !== 1'b0 || bus.PENDING !== 4'b0000 || bus.ERR_DUP !== 1'b0 || bus.OUT_IDX !== 2'd0) begin
            miss++;
            $display("FAIL reset_release: valid=%b pending=%b err=%b idx=%0d, want 0/0000/0/0", bus.OUT_VALID, bus.PENDING, bus.ERR_DUP, bus.OUT_IDX);
        end
    endtask

    task automatic test_single();
        do_reset();
        bus.E = 1'b1; bus.REQ = 4'b0100; bus.OUT_READY = 1'b1;
        tick();
        bus.REQ = '0;
        vecs++;
        if (bus.PENDING !== 4'b0100 || bus.OUT_VALID !== 1'b0) begin
            miss++;
            $display("FAIL single_pend: pending=%b valid=%b, want 0100/0", bus.PENDING, bus.OUT_VALID);
        end
        tick();
        vecs++;
        if (bus.OUT_VALID !== 1'b1 || bus.OUT_IDX !== 2'd2) begin
            miss++;
            $display("FAIL single_out: valid=%b idx=%0d, want 1/2", bus.OUT_VALID, bus.OUT_IDX);
        end
        tick();
        vecs++;
        if (bus.OUT_VALID !== 1'b0 || bus.PENDING !== 4'b0000) begin
            miss++;
            $display("FAIL single_done: valid=%b pending=%b, want 0/0000", bus.OUT_VALID, bus.PENDING);
        end
    endtask

    task automatic test_priority_backpressure();
        do_reset();
        bus.E = 1'b1; bus.REQ = 4'b1010; bus.OUT_READY = 1'b0;
        tick();
        bus.REQ = '0;
        tick();
        for (int i = 0; i < 5; i++) begin
            vecs++;
            if (bus.OUT_VALID !== 1'b1 || bus.OUT_IDX !== 2'd1) begin
                miss++;
                $display("FAIL bp_hold%0d: valid=%b idx=%0d, want 1/1", i, bus.OUT_VALID, bus.OUT_IDX);
            end
            if (i < 4) tick();
        end
        bus.OUT_READY = 1'b1;
        tick();
        vecs++;
        if (bus.OUT_VALID !== 1'b1 || bus.OUT_IDX !== 2'd3) begin
            miss++;
            $display("FAIL bp_second: valid=%b idx=%0d, want 1/3", bus.OUT_VALID, bus.OUT_IDX);
        end
        tick();
        vecs++;
        if (bus.OUT_VALID !== 1'b0 || bus.PENDING !== 4'b0000) begin
            miss++;
            $display("FAIL bp_done: valid=%b pending=%b, want 0/0000", bus.OUT_VALID, bus.PENDING);
        end
    endtask

    task automatic test_enable();
        do_reset();
        bus.E = 1'b0; bus.REQ = 4'b1111; bus.OUT_READY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vecs++;
            if (bus.PENDING !== 4'b0000 || bus.OUT_VALID !== 1'b0) begin
                miss++;
                $display("FAIL en_gate%0d: pending=%b valid=%b, want 0000/0", i, bus.PENDING, bus.OUT_VALID);
            end
        end
        bus.E = 1'b1; bus.REQ = 4'b0001;
        tick();
        bus.REQ = '0;
        tick();
        vecs++;
        if (bus.OUT_VALID !== 1'b1 || bus.OUT_IDX !== 2'd0) begin
            miss++;
            $display("FAIL en_out: valid=%b idx=%0d, want 1/0", bus.OUT_VALID, bus.OUT_IDX);
        end
        tick();
        vecs++;
        if (bus.OUT_VALID !== 1'b0) begin
            miss++;
            $display("FAIL en_done: valid=%b, want 0", bus.OUT_VALID);
        end
    endtask

    task automatic test_dup_repend();
        do_reset();
        bus.E = 1'b1; bus.REQ = 4'b0100; bus.OUT_READY = 1'b0;
        tick();
        vecs++;
        if (bus.ERR_DUP !== 1'b0) begin
            miss++;
            $display("FAIL dup_first: err=%b, want 0", bus.ERR_DUP);
        end
        tick();
        vecs++;
        if (bus.ERR_DUP !== 1'b1 || bus.PENDING !== 4'b0100) begin
            miss++;
            $display("FAIL dup_pulse: err=%b pending=%b, want 1/0100", bus.ERR_DUP, bus.PENDING);
        end
        bus.REQ = '0;
        tick();
        vecs++;
        if (bus.ERR_DUP !== 1'b0 || bus.OUT_VALID !== 1'b1 || bus.OUT_IDX !== 2'd2) begin
            miss++;
            $display("FAIL dup_clear: err=%b valid=%b idx=%0d, want 0/1/2", bus.ERR_DUP, bus.OUT_VALID, bus.OUT_IDX);
        end
        bus.OUT_READY = 1'b1; bus.REQ = 4'b0100;
        tick();
        bus.REQ = '0;
        vecs++;
        if (bus.ERR_DUP !== 1'b0 || bus.PENDING[2] !== 1'b1 || bus.OUT_VALID !== 1'b0) begin
            miss++;
            $display("FAIL repend_accept: err=%b pending=%b valid=%b, want 0/x1xx/0", bus.ERR_DUP, bus.PENDING, bus.OUT_VALID);
        end
        tick();
        vecs++;
        if (bus.OUT_VALID !== 1'b1 || bus.OUT_IDX !== 2'd2 || bus.ERR_DUP !== 1'b0) begin
            miss++;
            $display("FAIL repend_out: valid=%b idx=%0d err=%b, want 1/2/0", bus.OUT_VALID, bus.OUT_IDX, bus.ERR_DUP);
        end
        tick();
        vecs++;
        if (bus.OUT_VALID !== 1'b0 || bus.PENDING !== 4'b0000) begin
            miss++;
            $display("FAIL repend_done: valid=%b pending=%b, want 0/0000", bus.OUT_VALID, bus.PENDING);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.E = 1'b1; bus.REQ = 4'b1111; bus.OUT_READY = 1'b1;
        tick();
        bus.REQ = '0;
        tick();
        for (int i = 0; i < 4; i++) begin
            vecs++;
            if (bus.OUT_VALID !== 1'b1 || bus.OUT_IDX !== W'(i)) begin
                miss++;
                $display("FAIL b2b_idx%0d: valid=%b idx=%0d, want 1/%0d", i, bus.OUT_VALID, bus.OUT_IDX, i);
            end
            tick();
        end
        vecs++;
        if (bus.OUT_VALID !== 1'b0 || bus.PENDING !== 4'b0000) begin
            miss++;
            $display("FAIL b2b_done: valid=%b pending=%b, want 0/0000", bus.OUT_VALID, bus.PENDING);
        end
    endtask

    task automatic test_sustained();
        logic [W-1:0] exp_seq [5];
`ifdef PRIO_ENCODER_ROUND_ROBIN_EN
        exp_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`else
        exp_seq = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0};
`endif
        do_reset();
        bus.E = 1'b1; bus.REQ = 4'b1111; bus.OUT_READY = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            vecs++;
            if (bus.OUT_VALID !== 1'b1 || bus.OUT_IDX !== exp_seq[i]) begin
                miss++;
                $display("FAIL sustain_idx%0d: valid=%b idx=%0d, want 1/%0d", i, bus.OUT_VALID, bus.OUT_IDX, exp_seq[i]);
            end
            tick();
        end
        bus.REQ = '0; bus.OUT_READY = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority_backpressure();
        test_enable();
        test_dup_repend();
        test_back_to_back();
        test_sustained();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule
